// File: rtl/io_ctrl_responder.sv
// io_ctrl_responder: memory-mapped IO registers, switch sync, cycle counter and OLED request handshake
module io_ctrl_responder #(
    parameter int CYCLE_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            dataAddr,
    input  logic [31:0]            wrData,
    input  logic                   we,
    input  logic                   re,
    output logic                   isIO,
    output logic [31:0]            rdData,
    input  logic                   swStart,
    input  logic                   swCE,
    input  logic                   swCP,
    input  logic                   swCH,
    output logic                   sortFinish,
    output logic [CYCLE_WIDTH-1:0] sortCount,
    output logic [7:0]             lamp,
    output logic                   ledCtrl,
    output logic [CYCLE_WIDTH-1:0] cycleCount,
    output logic                   oledWe,
    output logic [5:0]             oledAddr,
    output logic [7:0]             oledData,
    output logic                   oledReq,
    output logic                   oledReqKind,
    input  logic                   oledAck
);
    typedef enum logic {IDLE, REQ} stateT;

    stateT      state;
    logic [6:0] idx;
    logic       ioWr;
    logic       reqWr;
    logic [3:0] swRaw;
    logic [3:0] swSync;
    logic       startPrev;
    logic       startRise;
    logic       startLatch;
    logic       startSetD;
    logic       startClr;
    logic       unusedAddr;

    assign isIO       = dataAddr[15];
    assign idx        = dataAddr[8:2];
    assign ioWr       = we && isIO;
    assign reqWr      = ioWr && (idx == 7'h09 || idx == 7'h0A);
    assign swRaw      = {swCH, swCP, swCE, swStart};
    assign startRise  = swSync[0] && !startPrev;
    assign startClr   = re && isIO && idx == 7'h10;
    assign unusedAddr = ^{dataAddr[14:9], dataAddr[1:0]};

    for (genvar g = 0; g < 4; g++) begin : gSync
        logic [SYNC_STAGES-1:0] chain;
        // shift each raw switch through its own synchroniser chain
        always_ff @(posedge clk or posedge rst)
            if (rst) chain <= '0;
            else     chain <= {chain[SYNC_STAGES-2:0], swRaw[g]};
        assign swSync[g] = chain[SYNC_STAGES-1];
    end

    // software-visible status and control registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sortFinish <= 1'b0;
            sortCount  <= '0;
            lamp       <= '0;
            ledCtrl    <= 1'b0;
        end else if (ioWr) begin
            if (idx == 7'h00) sortFinish <= wrData[0];
            if (idx == 7'h01) sortCount  <= wrData[CYCLE_WIDTH-1:0];
            if (idx == 7'h02) lamp       <= wrData[7:0];
            if (idx == 7'h03) ledCtrl    <= wrData[0];
        end

    // start latch (set beats clear) and the run timer restarted one cycle after a start
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            startPrev  <= 1'b0;
            startLatch <= 1'b0;
            startSetD  <= 1'b0;
            cycleCount <= '0;
        end else begin
            startPrev  <= swSync[0];
            startSetD  <= startRise;
            startLatch <= startRise || (startLatch && !startClr);
            cycleCount <= startSetD ? '0 : sortFinish ? cycleCount : cycleCount + CYCLE_WIDTH'(1);
        end

    // one-cycle character write pulse towards the OLED driver
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            oledWe   <= 1'b0;
            oledAddr <= '0;
            oledData <= '0;
        end else begin
            oledWe <= ioWr && idx[6];
            if (ioWr && idx[6]) begin
                oledAddr <= dataAddr[7:2];
                oledData <= wrData[7:0];
            end
        end

    // update/clear request handshake; new requests are dropped while one is pending
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            oledReq     <= 1'b0;
            oledReqKind <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (reqWr) begin
                        state       <= REQ;
                        oledReq     <= 1'b1;
                        oledReqKind <= idx[1];
                    end
                REQ:
                    if (oledAck) begin
                        state   <= IDLE;
                        oledReq <= 1'b0;
                    end
                default: begin
                    state   <= IDLE;
                    oledReq <= 1'b0;
                end
            endcase
        end

    // read mux, independent of re so the core can sample it in the load cycle
    always_comb begin
        rdData = '0;
        if (isIO)
            case (idx)
                7'h00:   rdData = {31'b0, sortFinish};
                7'h01:   rdData = 32'(sortCount);
                7'h02:   rdData = {24'b0, lamp};
                7'h03:   rdData = {31'b0, ledCtrl};
                7'h08:   rdData = {31'b0, !oledReq};
                7'h10:   rdData = {31'b0, startLatch};
                7'h11:   rdData = {31'b0, swSync[1]};
                7'h12:   rdData = {31'b0, swSync[2]};
                7'h13:   rdData = {31'b0, swSync[3]};
                7'h14:   rdData = 32'(cycleCount);
                default: rdData = '0;
            endcase
    end
endmodule

// File: tb/tb_io_ctrl_responder.sv
// tb_io_ctrl_responder: table-driven register checks, OLED write scoreboard and multi-cycle corner sequences
module tb_io_ctrl_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dataAddr = '0;
    logic [31:0] wrData = '0;
    logic        we = 1'b0, re = 1'b0;
    logic        swStart = 1'b0, swCE = 1'b0, swCP = 1'b0, swCH = 1'b0;
    logic        oledAck = 1'b0;
    logic        isIO, sortFinish, ledCtrl, oledWe, oledReq, oledReqKind;
    logic [31:0] rdData, sortCount, cycleCount;
    logic [7:0]  lamp, oledData;
    logic [5:0]  oledAddr;
    logic        isIO2, sortFinish2, ledCtrl2, oledWe2, oledReq2, oledReqKind2;
    logic [31:0] rdData2;
    logic [3:0]  sortCount2, cycleCount2;
    logic [7:0]  lamp2, oledData2;
    logic [5:0]  oledAddr2;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } owT;
    owT owQ[$];

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        w;
        logic        r;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vecT;
    vecT vecs[18];

    always #5 clk = ~clk;

    io_ctrl_responder dut (
        .clk(clk), .rst(rst), .dataAddr(dataAddr), .wrData(wrData), .we(we), .re(re),
        .isIO(isIO), .rdData(rdData), .swStart(swStart), .swCE(swCE), .swCP(swCP), .swCH(swCH),
        .sortFinish(sortFinish), .sortCount(sortCount), .lamp(lamp), .ledCtrl(ledCtrl),
        .cycleCount(cycleCount), .oledWe(oledWe), .oledAddr(oledAddr), .oledData(oledData),
        .oledReq(oledReq), .oledReqKind(oledReqKind), .oledAck(oledAck)
    );

    // narrow counter instance lets the wrap-around be reached in a few cycles
    io_ctrl_responder #(.CYCLE_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .dataAddr(dataAddr), .wrData(wrData), .we(we), .re(re),
        .isIO(isIO2), .rdData(rdData2), .swStart(swStart), .swCE(swCE), .swCP(swCP), .swCH(swCH),
        .sortFinish(sortFinish2), .sortCount(sortCount2), .lamp(lamp2), .ledCtrl(ledCtrl2),
        .cycleCount(cycleCount2), .oledWe(oledWe2), .oledAddr(oledAddr2), .oledData(oledData2),
        .oledReq(oledReq2), .oledReqKind(oledReqKind2), .oledAck(oledAck)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r,
                          output logic [31:0] rd);
        @(negedge clk);
        dataAddr = a;
        wrData   = d;
        we       = w;
        re       = r;
        if (w && a[15] && a[8]) owQ.push_back('{a[7:2], d[7:0]});
        #1 rd = rdData;
    endtask

    task automatic idle();
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        #1;
    endtask

    // every character pulse must match the oldest expected write
    always @(negedge clk)
        if (!rst && oledWe) begin
            if (owQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL oledWeSpurious: got pulse addr=%0d data=0x%02h expected none", oledAddr, oledData);
            end else begin
                owT e;
                e = owQ.pop_front();
                check("oledAddr", 32'(oledAddr), 32'(e.a));
                check("oledData", 32'(oledData), 32'(e.d));
            end
        end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, c0;
        logic        found;
        vecs[0]  = '{16'h8008, 32'h5A,       1, 0, 0, 32'h0,        "lampWr"};
        vecs[1]  = '{16'h800C, 32'h1,        1, 0, 0, 32'h0,        "ledWr"};
        vecs[2]  = '{16'h8008, 32'h0,        0, 1, 1, 32'h5A,       "lampRd"};
        vecs[3]  = '{16'h800C, 32'h0,        0, 1, 1, 32'h1,        "ledRd"};
        vecs[4]  = '{16'h8030, 32'h0,        0, 1, 1, 32'h0,        "unmapRd"};
        vecs[5]  = '{16'h8004, 32'hDEADBEEF, 1, 0, 0, 32'h0,        "cntWr"};
        vecs[6]  = '{16'h8004, 32'h0,        0, 1, 1, 32'hDEADBEEF, "cntRd"};
        vecs[7]  = '{16'h0008, 32'hFF,       1, 0, 0, 32'h0,        "nonIoWrA"};
        vecs[8]  = '{16'h8008, 32'h0,        0, 1, 1, 32'h5A,       "nonIoWr"};
        vecs[9]  = '{16'h0008, 32'h0,        0, 1, 1, 32'h0,        "nonIoRd"};
        vecs[10] = '{16'h8030, 32'h12345678, 1, 0, 0, 32'h0,        "unmapWrA"};
        vecs[11] = '{16'h8004, 32'h0,        0, 1, 1, 32'hDEADBEEF, "unmapWr"};
        vecs[12] = '{16'h8020, 32'h0,        0, 1, 1, 32'h1,        "readyIdle"};
        vecs[13] = '{16'h8040, 32'h0,        0, 1, 1, 32'h0,        "startIdle"};
        vecs[14] = '{16'h8008, 32'h1A5,      1, 0, 0, 32'h0,        "lampWr2"};
        vecs[15] = '{16'h8008, 32'h0,        0, 0, 1, 32'hA5,       "noRe"};
        vecs[16] = '{16'h8000, 32'h0,        0, 1, 1, 32'h0,        "finRd"};
        vecs[17] = '{16'h804C, 32'h0,        0, 1, 1, 32'h0,        "chRd"};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("cycle10", cycleCount, 32'd10);
        check("lamp0", 32'(lamp), 32'h0);
        check("outs0", {sortFinish, ledCtrl, oledWe, oledReq, oledReqKind}, 32'h0);
        check("sortCount0", sortCount, 32'h0);
        dataAddr = 16'h8050;
        #1 check("cycleRd", rdData, 32'd10);
        check("isIO1", 32'(isIO), 32'h1);
        dataAddr = 16'h0050;
        #1 check("isIO0", 32'(isIO), 32'h0);

        for (int i = 0; i < 18; i++) begin
            access(vecs[i].addr, vecs[i].data, vecs[i].w, vecs[i].r, rd);
            if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
        end
        idle();
        check("lampOut", 32'(lamp), 32'hA5);
        check("ledOut", 32'(ledCtrl), 32'h1);
        check("sortCountOut", sortCount, 32'hDEADBEEF);
        check("mirror0", 32'(cycleCount2), 32'(cycleCount[3:0]));

        // switch synchroniser latency on CE
        @(negedge clk);
        swCE = 1'b1;
        dataAddr = 16'h8044;
        @(negedge clk);
        #1 check("ceSync1", rdData, 32'h0);
        @(negedge clk);
        #1 check("ceSync2", rdData, 32'h1);
        swCE = 1'b0;

        // start pulse: latched after SYNC_STAGES+1 edges, counter restarts one edge later
        @(negedge clk);
        swStart = 1'b1;
        dataAddr = 16'h8040;
        @(negedge clk);
        swStart = 1'b0;
        #1 check("start1", rdData, 32'h0);
        @(negedge clk);
        #1 check("start2", rdData, 32'h0);
        @(negedge clk);
        #1 check("start3", rdData, 32'h1);
        @(negedge clk);
        check("restart0", cycleCount, 32'h0);
        check("restart0n", 32'(cycleCount2), 32'h0);
        @(negedge clk);
        check("restart1", cycleCount, 32'h1);
        access(16'h8040, 0, 0, 1, rd);
        check("startRdClr", rd, 32'h1);
        idle();
        check("startCleared", rdData, 32'h0);

        // set and clear in the same cycle: set wins
        @(negedge clk);
        swStart = 1'b1;
        @(negedge clk);
        swStart = 1'b0;
        @(negedge clk);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        #1 check("setWins", rdData, 32'h1);
        access(16'h8040, 0, 0, 1, rd);
        idle();
        check("setWinsClr", rdData, 32'h0);

        // OLED characters, including back-to-back and filtered non-character writes
        access(16'h8104, 32'h41, 1, 0, rd);
        idle();
        idle();
        access(16'h81FC, 32'h5A, 1, 0, rd);
        access(16'h8100, 32'h17E, 1, 0, rd);
        access(16'h8080, 32'h33, 1, 0, rd);
        access(16'h0104, 32'h44, 1, 0, rd);
        idle();
        idle();
        check("owQEmpty", 32'(owQ.size()), 32'h0);

        // OLED update/clear handshake
        access(16'h8024, 0, 1, 0, rd);
        access(16'h8020, 0, 0, 1, rd);
        check("reqBusyRd", rd, 32'h0);
        check("reqUpd", {oledReq, oledReqKind}, 32'h2);
        access(16'h8028, 0, 1, 0, rd);
        idle();
        check("reqDropped", {oledReq, oledReqKind}, 32'h2);
        oledAck = 1'b1;
        @(negedge clk);
        oledAck = 1'b0;
        #1 check("ackDone", 32'(oledReq), 32'h0);
        access(16'h8020, 0, 0, 1, rd);
        check("readyRd", rd, 32'h1);
        idle();
        oledAck = 1'b1;
        @(negedge clk);
        oledAck = 1'b0;
        #1 check("ackIdle", 32'(oledReq), 32'h0);
        access(16'h8028, 0, 1, 0, rd);
        idle();
        check("reqClr", {oledReq, oledReqKind}, 32'h3);
        oledAck = 1'b1;
        @(negedge clk);
        oledAck = 1'b0;
        #1 check("ackClr", 32'(oledReq), 32'h0);
        access(16'h8024, 0, 1, 0, rd);
        idle();
        check("reqRelatch", {oledReq, oledReqKind}, 32'h2);

        // sortFinish freezes the counter, clearing it resumes
        access(16'h8000, 32'h1, 1, 0, rd);
        idle();
        c0 = cycleCount;
        repeat (5) @(negedge clk);
        check("freeze", cycleCount, c0);
        check("finOut", 32'(sortFinish), 32'h1);
        access(16'h8000, 32'h0, 1, 0, rd);
        idle();
        check("resumeHold", cycleCount, c0);
        repeat (3) @(negedge clk);
        check("resume", cycleCount, c0 + 32'd3);
        check("mirror1", 32'(cycleCount2), 32'(cycleCount[3:0]));

        // wrap of the narrow counter
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (cycleCount2 == 4'hF);
        end
        check("wrapReach", 32'(found), 32'h1);
        @(negedge clk);
        check("wrap", 32'(cycleCount2), 32'h0);

        // asynchronous reset while a request is pending
        check("reqBeforeRst", 32'(oledReq), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rstReq", 32'(oledReq), 32'h0);
        check("rstLamp", 32'(lamp), 32'h0);
        check("rstCycle", cycleCount, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
